// File: rtl/list_stream_harness_pkg.sv
// list_harness_pkg: shared types and constants for the list stream harness.
//   state_e      : harness FSM states
//   LED_*        : bit positions of the status flags on the board LEDs
//   LFSR_*       : seed/taps of the random-gap LFSR (used when
//                  LIST_HARNESS_RANDGAP_EN is defined)
//   lfsr_next()  : one step of the 16-bit Galois LFSR (taps 16,14,13,11)
package list_harness_pkg;

   typedef enum logic [2:0] {IDLE, GAP, REQ, CHECK, FINISH} state_e;

   localparam int LED_PASS = 7;
   localparam int LED_FAIL = 6;
   localparam int LED_TMO  = 5;
   localparam int LED_PERR = 4;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/list_stream_harness_if.sv
// list_stream_harness_if: harness <-> list-producing DUT connection.
//   dut_ready   harness -> DUT  start/enable, high while a run is active
//   req         harness -> DUT  element request
//   done_seen   harness -> DUT side observer: dut_done was seen during a run
//   dut_done    DUT -> harness  done flag (informational)
//   ack         DUT -> harness  acknowledge
//   value       DUT -> harness  list element
//   value_valid DUT -> harness  element present (0 with ack = end of list)
interface list_stream_harness_if #(parameter int DATA_W = 8);
   logic              dut_ready;
   logic              req;
   logic              done_seen;
   logic              dut_done;
   logic              ack;
   logic [DATA_W-1:0] value;
   logic              value_valid;

   modport master (output dut_ready, req, done_seen,
                   input  dut_done, ack, value, value_valid);
   modport slave  (input  dut_ready, req, done_seen,
                   output dut_done, ack, value, value_valid);
endinterface

// File: rtl/list_stream_harness_gap_gen.sv
// list_harness_gap_gen: inter-request gap timer.
//   clk, rst  : clock, async active-high reset
//   start     : pulse in the cycle the FSM enters GAP (loads the counter)
//   gap_done  : high once the loaded gap length has elapsed
// The GAP state lasts gap_len+1 cycles, so gap_len=0 still yields one
// req-low cycle. With LIST_HARNESS_RANDGAP_EN defined the length comes from
// a 16-bit LFSR (low bits, clamped to GAP_CYCLES) advanced on each start.
module list_harness_gap_gen
   import list_harness_pkg::*;
#(
   parameter int GAP_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic gap_done
);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

   logic [GW-1:0] cnt_q, cnt_d, gap_len;

`ifdef LIST_HARNESS_RANDGAP_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d  = start ? lfsr_next(lfsr_q) : lfsr_q;
      gap_len = (lfsr_q[GW-1:0] > GAP_MAX) ? GAP_MAX : lfsr_q[GW-1:0];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
`else
   assign gap_len = GAP_MAX;
`endif

   always_comb begin
      cnt_d = cnt_q;
      if (start)              cnt_d = gap_len;
      else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

   assign gap_done = (cnt_q == '0);
endmodule

// File: rtl/list_stream_harness.sv
// list_stream_harness: on-chip harness for list-producing dfd_* blocks.
// Starts the DUT, pulls elements over req/ack/value/value_valid with a gap
// between requests, counts elements, sums values, enforces an ack timeout
// and reports pass/fail on outputs and LEDs.
//   CLOCK_50, reset : clock, async active-high reset
//   go              : level, high starts/keeps a run, low aborts
//   bus             : DUT handshake (list_stream_harness_if.master)
//   busy/pass/fail  : run status
//   elem_count      : valid elements received (saturating)
//   checksum        : sum of values mod 2^DATA_W
//   LED             : {pass, fail, timeout, proto_err, elem_count[3:0]}
// Optional: LIST_HARNESS_RANDGAP_EN randomises each gap length.
module list_stream_harness
   import list_harness_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int CNT_W          = 8,
   parameter int GAP_CYCLES     = 10,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int EXPECT_COUNT   = 2,
   parameter int EXPECT_SUM     = 3
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  go,
   list_stream_harness_if.master bus,
   output logic                  busy,
   output logic                  pass,
   output logic                  fail,
   output logic [CNT_W-1:0]      elem_count,
   output logic [DATA_W-1:0]     checksum,
   output logic [7:0]            LED
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [TW-1:0]     to_q, to_d;
   logic              pass_q, pass_d, fail_q, fail_d;
   logic              tmo_q, tmo_d, perr_q, perr_d, ovf_q, ovf_d;
   logic              done_q, done_d;
   logic              gap_start, gap_done;

   // Counter is reloaded on every entry into GAP, from IDLE or from REQ.
   assign gap_start = (state_d == GAP) && (state_q != GAP);

   list_harness_gap_gen #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
      .clk      (CLOCK_50),
      .rst      (reset),
      .start    (gap_start),
      .gap_done (gap_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      to_d    = '0;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      perr_d  = perr_q;
      ovf_d   = ovf_q;
      done_d  = done_q | (busy & bus.dut_done);
      case (state_q)
         IDLE: if (go) begin
            state_d = GAP;
            cnt_d   = '0;
            sum_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            tmo_d   = 1'b0;
            perr_d  = 1'b0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
         end
         GAP: if (!go) begin
            state_d = IDLE;
         end else begin
            if (bus.ack)  perr_d  = 1'b1;
            if (gap_done) state_d = REQ;
         end
         REQ: if (!go) begin
            // abort beats a same-cycle ack: the element is dropped
            state_d = IDLE;
         end else if (bus.ack) begin
            if (bus.value_valid) begin
               sum_d = sum_q + bus.value;
               if (cnt_q == CNT_MAX) ovf_d = 1'b1;
               else                  cnt_d = cnt_q + 1'b1;
               state_d = GAP;
            end else begin
               state_d = CHECK;
            end
         end else if (to_q == TO_LAST) begin
            tmo_d   = 1'b1;
            fail_d  = 1'b1;
            state_d = FINISH;
         end else begin
            to_d = to_q + 1'b1;
         end
         CHECK: if (!go) begin
            state_d = IDLE;
         end else begin
            if (cnt_q == CNT_W'(EXPECT_COUNT) && sum_q == DATA_W'(EXPECT_SUM)
                && !tmo_q && !perr_q && !ovf_q)
               pass_d = 1'b1;
            else
               fail_d = 1'b1;
            state_d = FINISH;
         end
         // result stays visible in IDLE until the next go rise clears it
         FINISH: if (!go) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         to_q    <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
         perr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         to_q    <= to_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         perr_q  <= perr_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end

   // Decoded straight from state so reset clears them asynchronously.
   assign busy          = (state_q == GAP) || (state_q == REQ) || (state_q == CHECK);
   assign bus.dut_ready = busy;
   assign bus.req       = (state_q == REQ);
   assign bus.done_seen = done_q;
   assign pass          = pass_q;
   assign fail          = fail_q;
   assign elem_count    = cnt_q;
   assign checksum      = sum_q;

   always_comb begin
      LED           = {4'b0000, cnt_q[3:0]};
      LED[LED_PASS] = pass_q;
      LED[LED_FAIL] = fail_q;
      LED[LED_TMO]  = tmo_q;
      LED[LED_PERR] = perr_q;
   end
endmodule

// File: tb/tb_list_stream_harness.sv
// Randomised self-checking bench for list_stream_harness (default parameters).
// A behavioural DUT model answers requests from a list with random ack delay;
// expected count/sum/result come from the list contents directly.
module tb_list_stream_harness;
   localparam int GAP = 10, TMO = 1000, EXP_CNT = 2, EXP_SUM = 3;

   logic       clk = 1'b0;
   logic       rst, go;
   logic       busy, pass, fail;
   logic [7:0] elem_count, checksum, led;
   int         checks = 0, failures = 0;
   int         lst[8];
   int         lst_len;

   list_stream_harness_if #(.DATA_W(8)) bus();

   list_stream_harness #(
      .DATA_W(8), .CNT_W(8), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO),
      .EXPECT_COUNT(EXP_CNT), .EXPECT_SUM(EXP_SUM)
   ) dut (
      .CLOCK_50(clk), .reset(rst), .go(go), .bus(bus),
      .busy(busy), .pass(pass), .fail(fail),
      .elem_count(elem_count), .checksum(checksum), .LED(led)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      bus.ack = 1'b0; bus.value_valid = 1'b0; bus.value = 8'h00; bus.dut_done = 1'b0;
   endtask

   // Full run of the current list; proto_cyc >= 0 pulses ack in the first gap.
   task automatic run_list(input string tag, input int proto_cyc, input bit done_pulse);
      int cyc = 0, idx = 0, wait_c, fall_cyc = -1;
      bit prev_req = 1'b0, finished = 1'b0, perr, epass;
      logic [7:0] esum = 8'h00;
      for (int i = 0; i < lst_len; i++) esum = esum + 8'(lst[i]);
      perr  = (proto_cyc >= 0);
      epass = !perr && lst_len == EXP_CNT && esum == 8'(EXP_SUM);
      wait_c = $urandom_range(0, 3);
      go = 1'b1;
      @(negedge clk);
      chk({tag, "_start_busy"}, busy, 1);
      chk({tag, "_start_clr"}, {pass, fail, elem_count, checksum}, 0);
      while (!finished && cyc < 3000) begin
         bus.ack = 1'b0; bus.value_valid = 1'b0; bus.value = 8'($urandom);
         bus.dut_done = done_pulse && cyc == 5;
         if (bus.req) begin
            if (!prev_req && fall_cyc >= 0) chk({tag, "_gap"}, cyc - fall_cyc, GAP + 1);
            if (wait_c == 0) begin
               bus.ack = 1'b1;
               bus.value_valid = (idx < lst_len);
               if (idx < lst_len) begin bus.value = 8'(lst[idx]); idx++; end
               wait_c = $urandom_range(0, 3);
            end else wait_c--;
         end else begin
            if (prev_req) fall_cyc = cyc;
            if (cyc == proto_cyc) begin bus.ack = 1'b1; bus.value_valid = 1'b1; end
         end
         prev_req = bus.req;
         @(negedge clk);
         cyc++;
         finished = pass | fail;
      end
      idle_bus();
      chk({tag, "_finished"}, finished, 1);
      chk({tag, "_pass"}, pass, epass);
      chk({tag, "_fail"}, fail, !epass);
      chk({tag, "_count"}, elem_count, lst_len);
      chk({tag, "_sum"}, checksum, esum);
      chk({tag, "_led"}, led, {epass, !epass, 1'b0, perr, 4'(lst_len)});
      chk({tag, "_fin_out"}, {bus.req, bus.dut_ready, busy}, 0);
      if (done_pulse) chk({tag, "_done_seen"}, bus.done_seen, 1);
      go = 1'b0;
      @(negedge clk); @(negedge clk);
      chk({tag, "_held"}, {pass, fail, busy}, {epass, !epass, 1'b0});
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.req && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_req_seen"}, bus.req, 1);
   endtask

   initial begin
      int hi;
      rst = 1'b1; go = 1'b0; idle_bus();
      @(negedge clk); @(negedge clk);
      chk("rst_out", {bus.req, bus.dut_ready, busy, pass, fail}, 0);
      chk("rst_cnt", {elem_count, checksum}, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_out", {bus.req, busy, pass, fail, led}, 0);

      lst[0] = 1; lst[1] = 2; lst_len = 2;
      run_list("l12", -1, 1'b1);
      lst[0] = 5; lst[1] = 7; lst_len = 2;
      run_list("l57", -1, 1'b0);
      lst[0] = 1; lst[1] = 2; lst_len = 2;
      run_list("proto", 3, 1'b0);

      // never ack: req must stay high for exactly TMO cycles
      go = 1'b1;
      wait_req("tmo");
      hi = 0;
      while (bus.req && hi < 2000) begin @(negedge clk); hi++; end
      chk("tmo_len", hi, TMO);
      chk("tmo_fail", {pass, fail}, 2'b01);
      chk("tmo_led5", led[5], 1);
      chk("tmo_req", bus.req, 0);
      go = 1'b0;
      @(negedge clk); @(negedge clk);

      // abort in the same cycle as the second ack (value 9)
      go = 1'b1;
      wait_req("abort1");
      bus.ack = 1'b1; bus.value_valid = 1'b1; bus.value = 8'd4;
      @(negedge clk);
      idle_bus();
      wait_req("abort2");
      bus.ack = 1'b1; bus.value_valid = 1'b1; bus.value = 8'd9; go = 1'b0;
      @(negedge clk);
      idle_bus();
      chk("abort_out", {bus.req, bus.dut_ready, busy, pass, fail}, 0);
      chk("abort_sum", checksum, 4);
      chk("abort_cnt", elem_count, 1);
      @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         lst_len = $urandom_range(0, 5);
         for (int i = 0; i < lst_len; i++) lst[i] = $urandom_range(0, 3);
         if (r == 0) begin lst_len = 2; lst[0] = 2; lst[1] = 1; end
         run_list($sformatf("rnd%0d", r), -1, 1'b0);
      end

      // reset during REQ clears outputs without a clock edge
      go = 1'b1;
      wait_req("rstrun");
      #2 rst = 1'b1;
      #1 chk("rst_async", {bus.req, bus.dut_ready, busy}, 0);
      go = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_after", {bus.req, bus.dut_ready, busy, pass, fail, elem_count, checksum, led}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
